// File: rtl/cu_pkg.sv
// Shared constants and helpers for the cu_engine_pipe sliding-window compute unit.
package cu_pkg;

  localparam int K_DEF    = 3;
  localparam int DW_DEF   = 8;
  localparam int OUTW_DEF = 16;

  // Flat weight/product index for window tap (row r, column c); column 0 is the oldest.
  function automatic int tap_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Clamp a sign-extended accumulator into the signed range of an outw-bit result.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int                 outw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (outw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (outw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cu_adder_tree.sv
// N-input signed summation of a flat vector of IW-bit terms into an OW-bit sum (combinational).
module cu_adder_tree #(
  parameter int N  = 9,
  parameter int IW = 16,
  parameter int OW = 20
) (
  input  logic [N*IW-1:0]    in_i,
  output logic signed [OW-1:0] sum_o
);

  logic signed [IW-1:0] term;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sum_o = '0;
    term  = '0;
    for (int i = 0; i < N; i++) begin
      term  = in_i[i*IW +: IW];
      sum_o = sum_o + OW'(term);
    end
  end

endmodule

// File: rtl/cu_engine_pipe.sv
// Pipelined KxK sliding-window MAC with saturated valid/ready output.
// Optional CU_ENGINE_RELU_EN clamps negative saturated results to zero in S3.
module cu_engine_pipe
  import cu_pkg::*;
#(
  parameter int K    = K_DEF,
  parameter int DW   = DW_DEF,
  parameter int OUTW = OUTW_DEF
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                filter_load,
  input  logic [K*K*DW-1:0]   filter_in,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [K*DW-1:0]     data_in,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTW-1:0]     pe_out,
  output logic                out_last
);

  localparam int SUMW = 2 * DW + $clog2(K * K);
  localparam int PW   = 2 * DW;
  localparam int NT   = K * K;
  localparam int FCW  = $clog2(K + 1);

  logic [K*K*DW-1:0]      filter_q;
  logic [K*DW-1:0]        win_q [K-1];
  logic [FCW-1:0]         fill_q, fill_d;
  logic                   s1_valid_q, s1_last_q;
  logic [NT*PW-1:0]       prod_q, prod_d;
  logic                   s2_valid_q, s2_last_q;
  logic signed [SUMW-1:0] sum_q, sum_d;
  logic                   out_valid_q, out_last_q;
  logic [OUTW-1:0]        pe_out_q;
  logic signed [OUTW-1:0] sat_d;

  logic                   stall, accept, win_done, load_en;
  logic [K*DW-1:0]        cols [K];
  logic signed [DW-1:0]   pix, wgt;
  logic signed [PW-1:0]   prod;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && !stall;
  assign win_done = accept && (fill_q >= FCW'(K - 1));
  assign busy     = in_valid || s1_valid_q || s2_valid_q || out_valid_q;
  assign load_en  = filter_load && !busy;

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign pe_out    = pe_out_q;

  always_comb begin
    fill_d = fill_q;
    if (accept) begin
      if (in_last)                fill_d = '0;
      else if (fill_q != FCW'(K)) fill_d = fill_q + 1'b1;
    end
  end

  // S1 multiplies the window as it will look after this accept, so the new column counts immediately.
  always_comb begin
    for (int c = 0; c < K - 1; c++) cols[c] = win_q[c];
    cols[K-1] = data_in;
    prod_d = '0;
    pix    = '0;
    wgt    = '0;
    prod   = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        pix  = cols[c][r*DW +: DW];
        wgt  = filter_q[tap_idx(r, c, K)*DW +: DW];
        prod = pix * wgt;
        prod_d[tap_idx(r, c, K)*PW +: PW] = prod;
      end
    end
  end

  cu_adder_tree #(
    .N (NT),
    .IW(PW),
    .OW(SUMW)
  ) u_adder_tree (
    .in_i (prod_q),
    .sum_o(sum_d)
  );

  always_comb begin
    sat_d = OUTW'(sat_signed(64'(sum_q), OUTW));
`ifdef CU_ENGINE_RELU_EN
    if (sat_d[OUTW-1]) sat_d = '0;
`else
    sat_d = sat_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: filter and window are small register arrays, reset here so a reset also clears weights.
      filter_q <= '0;
      for (int i = 0; i < K - 1; i++) win_q[i] <= '0;
      fill_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pe_out_q    <= '0;
    end else begin
      if (load_en) filter_q <= filter_in;
      if (accept) begin
        for (int i = 0; i < K - 2; i++) win_q[i] <= win_q[i+1];
        win_q[K-2] <= data_in;
        fill_q     <= fill_d;
      end
      // The whole pipe advances together; bubbles travel as cleared valid bits.
      if (!stall) begin
        s1_valid_q  <= win_done;
        s1_last_q   <= win_done && in_last;
        if (win_done) prod_q <= prod_d;
        s2_valid_q  <= s1_valid_q;
        s2_last_q   <= s1_last_q;
        if (s1_valid_q) sum_q <= sum_d;
        out_valid_q <= s2_valid_q;
        out_last_q  <= s2_last_q;
        if (s2_valid_q) pe_out_q <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_cu_engine_pipe.sv
// Scoreboard bench for cu_engine_pipe: a column-history reference model feeds an expected queue,
// and a separate monitor pops and compares each handshaken result.
module tb_cu_engine_pipe;

  localparam int K    = 3;
  localparam int DW   = 8;
  localparam int OUTW = 16;
  localparam int CW   = K * DW;
  localparam int FW   = K * K * DW;
`ifdef CU_ENGINE_RELU_EN
  localparam logic [OUTW-1:0] SAT_LO_EXP = 16'h0000;
`else
  localparam logic [OUTW-1:0] SAT_LO_EXP = 16'h8000;
`endif

  logic            clk = 1'b0, nrst = 1'b0;
  logic            filter_load = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [FW-1:0]   filter_in = '0;
  logic [CW-1:0]   data_in = '0;
  logic            busy, in_ready, out_valid, out_last;
  logic [OUTW-1:0] pe_out;

  cu_engine_pipe #(.K(K), .DW(DW), .OUTW(OUTW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .filter_load(filter_load),
    .filter_in  (filter_in),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pe_out     (pe_out),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUTW-1:0] val;
    logic            last;
  } exp_t;

  exp_t            exp_q[$];
  logic [CW-1:0]   row_q[$];
  int              filt_m[K*K];
  int              vectors = 0, miscompares = 0;
  int              ready_mode = 0;   // 0: ready, 1: not ready, 2: random
  int              stall_cycles = 0, out_count = 0;
  bit              held = 1'b0;
  logic [OUTW-1:0] held_val = '0;
  exp_t            mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_ref(input longint s);
    longint r;
    r = s;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`ifdef CU_ENGINE_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  task automatic model_load(input logic [FW-1:0] f);
    logic signed [DW-1:0] w;
    for (int i = 0; i < K * K; i++) begin
      w = f[i*DW +: DW];
      filt_m[i] = int'(w);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    row_q.delete();
    for (int i = 0; i < K * K; i++) filt_m[i] = 0;
  endtask

  // Keep the last K columns of the current row; a full history is a window.
  task automatic model_accept(input logic [CW-1:0] d, input logic last);
    longint               sum;
    logic [CW-1:0]        col;
    logic signed [DW-1:0] px;
    exp_t                 e;
    row_q.push_back(d);
    if (row_q.size() > K) void'(row_q.pop_front());
    if (row_q.size() == K) begin
      sum = 0;
      for (int c = 0; c < K; c++) begin
        col = row_q[c];
        for (int r = 0; r < K; r++) begin
          px  = col[r*DW +: DW];
          sum = sum + longint'(filt_m[r*K+c]) * longint'(px);
        end
      end
      e.val  = OUTW'(sat_ref(sum));
      e.last = last;
      exp_q.push_back(e);
    end
    if (last) row_q.delete();
  endtask

  function automatic logic [FW-1:0] rand_filter();
    logic [FW-1:0] f;
    for (int i = 0; i < K * K; i++) f[i*DW +: DW] = DW'($urandom());
    return f;
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares every handshaken result and checks stability while stalled.
  always @(negedge clk) begin
    #2;
    if (!nrst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", pe_out, held_val);
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got 0x%0h with no result expected at %0t", pe_out, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_value", pe_out, mon_e.val);
          check("out_last", out_last, mon_e.last);
        end
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        stall_cycles++;
        held     = 1'b1;
        held_val = pe_out;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send_col(input logic [CW-1:0] d, input logic last,
                          input logic ld = 1'b0, input logic [FW-1:0] f = '0);
    int waited;
    waited      = 0;
    in_valid    = 1'b1;
    data_in     = d;
    in_last     = last;
    filter_load = ld;
    filter_in   = f;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready held 0 for %0d cycles", waited);
    end else begin
      model_accept(d, last);
    end
    @(negedge clk);
    in_valid    = 1'b0;
    in_last     = 1'b0;
    filter_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic load_filter(input logic [FW-1:0] f);
    drain();
    check("load_idle_busy", busy, 0);
    filter_load = 1'b1;
    filter_in   = f;
    model_load(f);
    @(negedge clk);
    filter_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, len;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_pe_out", pe_out, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Diagonal filter: first result three edges after the third accept.
    load_filter(72'h010000000100000001);
    send_col(24'h020100, 1'b0);
    send_col(24'h050403, 1'b0);
    send_col(24'h080706, 1'b0);
    #2 check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    #2 check("lat_cycle2", out_valid, 0);
    @(negedge clk);
    #2 check("lat_cycle3", out_valid, 1);
    check("diag_first", pe_out, 16'h000C);
    send_col(24'h0b0a09, 1'b1);
    repeat (2) @(negedge clk);
    #2 check("diag_second", pe_out, 16'h0015);
    check("diag_second_last", out_last, 1);
    drain();

    // Saturation extremes.
    load_filter({9{8'h7f}});
    send_col(24'h7f7f7f, 1'b0);
    send_col(24'h7f7f7f, 1'b0);
    send_col(24'h7f7f7f, 1'b1);
    repeat (2) @(negedge clk);
    #2 check("sat_high", pe_out, 16'h7FFF);
    load_filter({9{8'h80}});
    send_col(24'h7f7f7f, 1'b0);
    send_col(24'h7f7f7f, 1'b0);
    send_col(24'h7f7f7f, 1'b1);
    repeat (2) @(negedge clk);
    #2 check("sat_low", pe_out, SAT_LO_EXP);
    drain();

    // Backpressure with results pending.
    load_filter(rand_filter());
    ready_mode   = 1;
    stall_cycles = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) send_col(CW'($urandom()), i == 5);
      end
      begin
        repeat (10) @(negedge clk);
        ready_mode = 0;
      end
    join
    drain();
    check("bp_stall_cycles_ge4", stall_cycles >= 4, 1);

    // Row end: 4 columns closing a row, then 3 columns of the next row.
    load_filter(rand_filter());
    base = out_count;
    for (int i = 0; i < 4; i++) send_col(CW'($urandom()), i == 3);
    for (int i = 0; i < 3; i++) send_col(CW'($urandom()), i == 2);
    drain();
    check("row_end_results", out_count - base, 3);

    // Filter load while busy is ignored.
    load_filter(rand_filter());
    send_col(CW'($urandom()), 1'b0);
    send_col(CW'($urandom()), 1'b0, 1'b1, rand_filter());
    for (int i = 0; i < 3; i++) send_col(CW'($urandom()), i == 2);
    drain();

    // Reset mid-stream.
    load_filter(rand_filter());
    for (int i = 0; i < 4; i++) send_col(CW'($urandom()), 1'b0);
    @(negedge clk);
    #3 nrst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_pe_out", pe_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    model_reset();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_col(CW'($urandom()) | 24'h010101, i == 2);
    drain();
    load_filter(rand_filter());
    base = out_count;
    for (int i = 0; i < 3; i++) send_col(CW'($urandom()), i == 2);
    drain();
    check("post_rst_results", out_count - base, 1);

    // Randomized rows with random backpressure and stray busy-time loads.
    for (int row = 0; row < 40; row++) begin
      if ($urandom_range(0, 3) == 0) load_filter(rand_filter());
      ready_mode = 2;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        send_col(CW'($urandom()), i == len - 1, $urandom_range(0, 7) == 0, rand_filter());
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
